sqrt_arb: RTL and testbench
===========================

SQRT_ARB -- requirements
Module: sqrt_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter SQRT_LAT, default 17: fixed cycles from sqrt_valid_in to sqrt_valid_out of the attached sqrt_u32 pipeline.
REQ-003 SHALL have parameter DATA_WIDTH, default 32; result width Q_WIDTH = DATA_WIDTH/2.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port enable, input, 1: when low, no new requests are granted.
REQ-007 SHALL have port req_valid, input, NREQ: per-requester request valid.
REQ-008 SHALL have port req_data, input, NREQ*DATA_WIDTH: per-requester radicand; slice i is requester i.
REQ-009 SHALL have port req_ready, output, NREQ: per-requester grant, combinational, one-hot or zero.
REQ-010 SHALL have port sqrt_valid_in, output, 1: issue strobe to the sqrt pipeline.
REQ-011 SHALL have port sqrt_data_i, output, DATA_WIDTH: radicand to the sqrt pipeline.
REQ-012 SHALL have port sqrt_valid_out, input, 1: result strobe from the sqrt pipeline.
REQ-013 SHALL have port sqrt_data_o, input, Q_WIDTH: root from the sqrt pipeline.
REQ-014 SHALL have port rsp_valid, output, NREQ: per-requester one-cycle result strobe, one-hot or zero.
REQ-015 SHALL have port rsp_data, output, Q_WIDTH: root, shared by all requesters.
REQ-016 SHALL have port busy, output, 1: high while any issued operation is outstanding.
REQ-017 SHALL have port err_orphan, output, 1: sticky flag for a sqrt result with no matching tag.

Function
REQ-018 SHALL set req_ready[i] = enable & req_valid[i] & (i is the first requester with req_valid set, searching from rr_ptr upward modulo NREQ).
REQ-019 SHALL count a handshake when req_valid[i] & req_ready[i]; at most one handshake per cycle.
REQ-020 SHALL, after a handshake, set rr_ptr to (i+1) mod NREQ; rr_ptr SHALL be unchanged in cycles without a handshake.
REQ-021 SHALL register the handshake: next cycle sqrt_valid_in=1, sqrt_data_i=req_data slice i; otherwise sqrt_valid_in=0 and sqrt_data_i=0.
REQ-022 SHALL accept one issue per cycle, back-to-back; the sqrt pipeline cannot stall and has no backpressure.
REQ-023 SHALL keep a tag shift register of SQRT_LAT entries (valid bit + log2(NREQ)-bit id), loaded with the id on the issue cycle and advanced every cycle.
REQ-024 SHALL, on sqrt_valid_out with a valid tag at the output entry, register next cycle rsp_valid[id]=1 and rsp_data=sqrt_data_o.
REQ-025 SHALL make the end-to-end latency from handshake to rsp_valid exactly SQRT_LAT+2 cycles, with responses in issue order.
REQ-026 SHALL hold rsp_data at 0 in cycles where no rsp_valid bit is set.
REQ-027 SHALL, on sqrt_valid_out with an invalid output tag entry, drop the result, assert no rsp_valid bit, and set err_orphan to 1 until reset.
REQ-028 SHALL ignore, without error, a valid output tag entry with sqrt_valid_out=0; the tag is discarded.
REQ-029 SHALL drive busy=1 when sqrt_valid_in is high, or any tag entry is valid, or any rsp_valid bit is high.
REQ-030 SHALL, when enable falls, still complete all outstanding operations; only new grants are blocked.
REQ-031 SHALL take no action on requesters that drop req_valid without a grant; the arbiter does not latch requests.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, clear sqrt_valid_in, sqrt_data_i, rsp_valid, rsp_data, err_orphan and all tag entries, and set rr_ptr=0.
REQ-033 SHALL, when rst is asserted mid-operation, abandon all in-flight tags; results emerging later SHALL be treated per REQ-027. The integrator SHALL reset the sqrt pipeline together with this block.
REQ-034 SHALL force req_ready=0 during any cycle with rst=1.

Verification
REQ-035 SHALL cover: a single request, requester 2, data 0x0000_0010 -> sqrt_valid_in one cycle later; rsp_valid[2]=1 with rsp_data=0x0004 exactly 19 cycles after the handshake.
REQ-036 SHALL cover: all 4 requesters valid continuously from reset -> grants in order 0,1,2,3,0,...; one issue per cycle; responses in the same order, each with the correct id.
REQ-037 SHALL cover: requester 1 sends 0xFFFF_FFFF and requester 3 sends 0x000F_4240 back-to-back -> rsp_data=0xFFFF then 0x03E8 on consecutive cycles.
REQ-038 SHALL cover: enable=0 while 3 operations are in flight -> req_ready stays 0, all 3 responses are delivered, and busy falls after the last one.
REQ-039 SHALL cover: rst pulsed with 5 operations in flight -> no rsp_valid afterwards and err_orphan=0, given the sqrt pipeline is reset in the same cycle.
REQ-040 SHALL cover: sqrt_valid_out forced high with no issue -> rsp_valid stays 0 and err_orphan=1 until rst.

Source files
------------

// File: rtl/sqrt_arb.sv
// sqrt_arb: round-robin front end for a shared, fixed-latency sqrt pipeline.
// Requesters are granted one per cycle, the issue is registered towards the
// pipeline, and a tag line tracks which requester owns each result so the
// root can be returned to it SQRT_LAT+2 cycles after the handshake.
module sqrt_arb #(
    parameter int NREQ       = 4,
    parameter int SQRT_LAT   = 17,
    parameter int DATA_WIDTH = 32,
    localparam int Q_WIDTH   = DATA_WIDTH / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       sqrt_valid_in,
    output logic [DATA_WIDTH-1:0]      sqrt_data_i,
    input  logic                       sqrt_valid_out,
    input  logic [Q_WIDTH-1:0]         sqrt_data_o,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [Q_WIDTH-1:0]         rsp_data,
    output logic                       busy,
    output logic                       err_orphan
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic [ID_W:0]   cand;
    logic            handshake;
    logic [ID_W-1:0] issue_id;

    // tag line: entry 0 is loaded on the issue cycle, entry SQRT_LAT-1 lines
    // up with sqrt_valid_out of the same operation
    logic [SQRT_LAT-1:0] tag_vld;
    logic [ID_W-1:0]     tag_id [SQRT_LAT];

    // first valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // grant is combinational; blocked while disabled or held in reset
    always_comb begin
        req_ready = '0;
        if (enable && !rst && grant_found) begin
            req_ready = NREQ'(1) << grant_id;
        end
    end

    assign handshake = |(req_valid & req_ready);

    // pointer moves just past the winner, only on a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // register the winning radicand and its owner towards the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            sqrt_valid_in <= 1'b0;
            sqrt_data_i   <= '0;
            issue_id      <= '0;
        end else begin
            sqrt_valid_in <= handshake;
            sqrt_data_i   <= handshake ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
            issue_id      <= handshake ? grant_id : '0;
        end
    end

    // tag line advances every cycle; the pipeline never stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int k = 0; k < SQRT_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld[0] <= sqrt_valid_in;
            tag_id[0]  <= issue_id;
            for (int k = 1; k < SQRT_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // route a tagged result to its owner; an untagged result is dropped and
    // flagged, a tag without a result is silently discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            if (sqrt_valid_out) begin
                if (tag_vld[SQRT_LAT-1]) begin
                    rsp_valid <= NREQ'(1) << tag_id[SQRT_LAT-1];
                    rsp_data  <= sqrt_data_o;
                end else begin
                    err_orphan <= 1'b1;
                end
            end
        end
    end

    assign busy = sqrt_valid_in | (|tag_vld) | (|rsp_valid);

endmodule

// File: tb/tb_sqrt_arb.sv
// Bench for sqrt_arb: a behavioural sqrt pipeline plus a scoreboard model of
// round-robin arbitration and response timing.
module tb_sqrt_arb;

    localparam int NREQ = 4;
    localparam int SQ   = 17;
    localparam int DW   = 32;
    localparam int QW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              sqrt_valid_in;
    logic [DW-1:0]     sqrt_data_i;
    logic              sqrt_valid_out;
    logic [QW-1:0]     sqrt_data_o;
    logic [NREQ-1:0]   rsp_valid;
    logic [QW-1:0]     rsp_data;
    logic              busy;
    logic              err_orphan;

    logic force_vout = 1'b0;
    logic suppress   = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        int          id;
        logic [QW-1:0] root;
    } exp_t;

    exp_t mq[$];
    int   m_rr = 0;
    logic m_orphan = 1'b0;

    sqrt_arb #(.NREQ(NREQ), .SQRT_LAT(SQ), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sqrt_valid_in(sqrt_valid_in), .sqrt_data_i(sqrt_data_i),
        .sqrt_valid_out(sqrt_valid_out), .sqrt_data_o(sqrt_data_o),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [QW-1:0] isqrt(input logic [DW-1:0] x);
        longint r = 0;
        longint t;
        for (int b = QW - 1; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return r[QW-1:0];
    endfunction

    // fixed-latency sqrt pipeline, reset together with the arbiter
    logic [SQ-1:0] pv;
    logic [QW-1:0] pd [SQ];
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < SQ; i++) pd[i] <= '0;
        end else begin
            pv    <= {pv[SQ-2:0], sqrt_valid_in};
            pd[0] <= isqrt(sqrt_data_i);
            for (int i = 1; i < SQ; i++) pd[i] <= pd[i-1];
        end
    end
    assign sqrt_valid_out = (pv[SQ-1] & ~suppress) | force_vout;
    assign sqrt_data_o    = pv[SQ-1] ? pd[SQ-1] : (force_vout ? 16'h5A5A : 16'h0000);

    function automatic logic [NREQ*DW-1:0] rand_data();
        logic [NREQ*DW-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 7))
                0: d[i*DW +: DW] = 32'h0000_0000;
                1: d[i*DW +: DW] = 32'hFFFF_FFFF;
                default: d[i*DW +: DW] = $urandom;
            endcase
        end
        return d;
    endfunction

    // drive one cycle at the falling edge and produce the expected outputs of
    // that cycle; the scoreboard is then advanced with this cycle's grant
    task automatic run_cycle(input logic r, input logic en, input logic [NREQ-1:0] v,
                             input logic [NREQ*DW-1:0] d,
                             output logic [NREQ-1:0] e_ready, output logic [NREQ-1:0] e_rv,
                             output logic [QW-1:0] e_rd, output logic e_busy,
                             output logic e_orph);
        @(negedge clk);
        rst       = r;
        enable    = en;
        req_valid = v;
        req_data  = d;
        #1;
        e_ready = '0;
        e_rv    = '0;
        e_rd    = '0;
        e_busy  = 1'b0;
        e_orph  = m_orphan;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            e_rv[mq[0].id] = 1'b1;
            e_rd = mq[0].root;
            void'(mq.pop_front());
            e_busy = 1'b1;
        end
        if (mq.size() > 0) e_busy = 1'b1;
        if (r) begin
            mq.delete();
            m_rr = 0;
            m_orphan = 1'b0;
        end else if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (v[i]) begin
                    e_ready[i] = 1'b1;
                    mq.push_back('{cyc + SQ + 2, i, isqrt(d[i*DW +: DW])});
                    m_rr = (i + 1) % NREQ;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b1, 1'b1, 4'hF, rand_data(), er, ev, ed, eb, eo);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
        end
        run_cycle(1'b0, 1'b0, '0, '0, er, ev, ed, eb, eo);
        n_checks++;
        if ({sqrt_valid_in, sqrt_data_i, rsp_valid, rsp_data, busy, err_orphan} !== {1'b0, 32'h0, 4'h0, 16'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state vin=%b data_i=%h rsp_valid=%b rsp_data=%h busy=%b orphan=%b (all zero required)",
                     sqrt_valid_in, sqrt_data_i, rsp_valid, rsp_data, busy, err_orphan);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        logic [NREQ*DW-1:0] d;
        int hc, lat;
        logic [NREQ-1:0] got_v;
        logic [QW-1:0] got_d;
        d = '0;
        d[2*DW +: DW] = 32'h0000_0010;
        run_cycle(1'b0, 1'b1, 4'b0100, d, er, ev, ed, eb, eo);
        hc = cyc;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_grant ready=%b required=0100", req_ready);
        end
        run_cycle(1'b0, 1'b1, '0, '0, er, ev, ed, eb, eo);
        n_checks++;
        if ({sqrt_valid_in, sqrt_data_i} !== {1'b1, 32'h0000_0010}) begin
            n_err++;
            $display("FAIL single_issue vin=%b data_i=%h required 1/00000010", sqrt_valid_in, sqrt_data_i);
        end
        lat = -1;
        got_v = '0;
        got_d = '0;
        for (int k = 0; k < 30; k++) begin
            run_cycle(1'b0, 1'b1, '0, '0, er, ev, ed, eb, eo);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL single_model cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
            if (rsp_valid != 0 && lat < 0) begin
                lat = cyc - hc;
                got_v = rsp_valid;
                got_d = rsp_data;
            end
        end
        n_checks++;
        if (lat != 19 || got_v !== 4'b0100 || got_d !== 16'h0004) begin
            n_err++;
            $display("FAIL single_latency lat=%0d rsp_valid=%b rsp_data=%h required 19/0100/0004", lat, got_v, got_d);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        run_cycle(1'b1, 1'b0, '0, '0, er, ev, ed, eb, eo);
        for (int k = 0; k < 48; k++) begin
            if (k < 24) run_cycle(1'b0, 1'b1, 4'hF, rand_data(), er, ev, ed, eb, eo);
            else        run_cycle(1'b0, 1'b1, 4'h0, '0, er, ev, ed, eb, eo);
            if (k < 24) begin
                n_checks++;
                if (req_ready !== (4'b0001 << (k % 4))) begin
                    n_err++;
                    $display("FAIL rr_order step=%0d ready=%b required=%b", k, req_ready, 4'b0001 << (k % 4));
                end
                n_checks++;
                if (k > 0 && sqrt_valid_in !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_issue step=%0d vin=%b required=1", k, sqrt_valid_in);
                end
            end
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL rr_model cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        logic [NREQ*DW-1:0] d;
        logic [QW-1:0] sd[$];
        logic [NREQ-1:0] sv[$];
        int sc[$];
        for (int k = 0; k < 27; k++) begin
            d = '0;
            if (k == 0) begin
                d[1*DW +: DW] = 32'hFFFF_FFFF;
                run_cycle(1'b0, 1'b1, 4'b0010, d, er, ev, ed, eb, eo);
            end else if (k == 1) begin
                d[3*DW +: DW] = 32'h000F_4240;
                run_cycle(1'b0, 1'b1, 4'b1000, d, er, ev, ed, eb, eo);
            end else begin
                run_cycle(1'b0, 1'b1, 4'b0000, d, er, ev, ed, eb, eo);
            end
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL b2b_model cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
            if (rsp_valid != 0) begin
                sd.push_back(rsp_data);
                sv.push_back(rsp_valid);
                sc.push_back(cyc);
            end
        end
        n_checks++;
        if (sd.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count responses=%0d required=2", sd.size());
        end else if (sd[0] !== 16'hFFFF || sv[0] !== 4'b0010 || sd[1] !== 16'h03E8 ||
                     sv[1] !== 4'b1000 || sc[1] != sc[0] + 1) begin
            n_err++;
            $display("FAIL b2b_data got %h@%b,%h@%b gap=%0d required FFFF@0010,03E8@1000 gap=1",
                     sd[0], sv[0], sd[1], sv[1], sc[1] - sc[0]);
        end
    endtask

    task automatic test_enable_low();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        int n_rsp;
        n_rsp = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b0, 1'b1, 4'hF, rand_data(), er, ev, ed, eb, eo);
            n_checks++;
            if (req_ready !== er) begin
                n_err++;
                $display("FAIL en_issue ready=%b required=%b", req_ready, er);
            end
        end
        for (int k = 0; k < 25; k++) begin
            run_cycle(1'b0, 1'b0, 4'hF, rand_data(), er, ev, ed, eb, eo);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL en_low_model cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
            if (rsp_valid != 0) n_rsp++;
        end
        n_checks++;
        if (n_rsp != 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL en_low_drain responses=%0d busy=%b required 3/0", n_rsp, busy);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        logic en;
        logic [NREQ-1:0] v;
        for (int k = 0; k < 325; k++) begin
            en = ($urandom_range(0, 9) != 0);
            v  = (k < 300) ? NREQ'($urandom) : '0;
            run_cycle(1'b0, en, v, rand_data(), er, ev, ed, eb, eo);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL random_model cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        int n_rsp;
        n_rsp = 0;
        for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b1, 4'hF, rand_data(), er, ev, ed, eb, eo);
        run_cycle(1'b1, 1'b1, 4'hF, rand_data(), er, ev, ed, eb, eo);
        n_checks++;
        if (req_ready !== 4'h0) begin
            n_err++;
            $display("FAIL rst_ready ready=%b required=0000", req_ready);
        end
        for (int k = 0; k < 30; k++) begin
            run_cycle(1'b0, 1'b0, '0, '0, er, ev, ed, eb, eo);
            if (rsp_valid != 0 || err_orphan !== 1'b0) n_rsp++;
        end
        n_checks++;
        if (n_rsp != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_inflight bad_cycles=%0d busy=%b required 0/0", n_rsp, busy);
        end
    endtask

    task automatic test_drop();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        int bad;
        bad = 0;
        suppress = 1'b1;
        run_cycle(1'b0, 1'b1, 4'b0001, rand_data(), er, ev, ed, eb, eo);
        for (int k = 0; k < 25; k++) begin
            run_cycle(1'b0, 1'b1, '0, '0, er, ev, ed, eb, eo);
            if (rsp_valid != 0 || err_orphan !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tag_drop bad_cycles=%0d busy=%b required 0/0", bad, busy);
        end
        suppress = 1'b0;
        mq.delete();
    endtask

    task automatic test_orphan();
        logic [NREQ-1:0] er, ev;
        logic [QW-1:0] ed;
        logic eb, eo;
        force_vout = 1'b1;
        run_cycle(1'b0, 1'b0, '0, '0, er, ev, ed, eb, eo);
        force_vout = 1'b0;
        m_orphan = 1'b1;
        for (int k = 0; k < 12; k++) begin
            run_cycle((k == 8), 1'b0, '0, '0, er, ev, ed, eb, eo);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, err_orphan} !== {er, ev, ed, eb, eo}) begin
                n_err++;
                $display("FAIL orphan cyc=%0d ready=%b/%b rsp_valid=%b/%b rsp_data=%h/%h busy=%b/%b orphan=%b/%b",
                         cyc, req_ready, er, rsp_valid, ev, rsp_data, ed, busy, eb, err_orphan, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_enable_low();
        test_random();
        test_reset_inflight();
        test_drop();
        test_orphan();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
